mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage).
- Holds at most one outstanding transaction at a time.
- Data side has fixed priority. A starvation counter forces a fetch grant after repeated data wins.
- Drives a memory port with fixed read latency and returns responses to the owning requester.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-port signal bundle for mem_port_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory, one transaction in flight.
// Optional single-entry fetch buffer enabled by defining ARB_FETCH_BUF_EN.
//
// state | meaning
// IDLE  | grant from requests; completed access reports rvalid here
// ISSUE | mem_en high for one cycle with the latched command
// WAIT  | count down memory latency, capture mem_rdata at count 1
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_q, state_d;

  logic              owner_if_q;
  logic              we_q;
  logic [LAT_W-1:0]  lat_q;
  logic [STV_W-1:0]  starve_q;

  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic grant_if, grant_d, buf_hit, done;

`ifdef ARB_FETCH_BUF_EN
  localparam int OFS_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    buf_hit  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gating with reset keeps both grants low while reset is held.
        if (!reset) begin
          if (bus.if_req && (!bus.d_req || starve_q == STV_MAX)) grant_if = 1'b1;
          else if (bus.d_req)                                   grant_d  = 1'b1;
        end
`ifdef ARB_FETCH_BUF_EN
        buf_hit = grant_if && buf_valid_q && (bus.if_addr == buf_addr_q);
`else
        buf_hit = 1'b0;
`endif
        if (grant_d || (grant_if && !buf_hit)) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_if_q  <= 1'b0;
      we_q        <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;

      if (grant_d) begin
        owner_if_q  <= 1'b0;
        we_q        <= bus.d_we;
        mem_en_q    <= 1'b1;
        mem_we_q    <= bus.d_we;
        mem_be_q    <= bus.d_be;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        if (bus.if_req && starve_q != STV_MAX) starve_q <= starve_q + STV_W'(1);
      end

      if (grant_if) begin
        starve_q <= '0;
        if (!buf_hit) begin
          owner_if_q <= 1'b1;
          we_q       <= 1'b0;
          mem_en_q   <= 1'b1;
          mem_be_q   <= '1;
          mem_addr_q <= bus.if_addr;
        end
      end

`ifdef ARB_FETCH_BUF_EN
      if (buf_hit) begin
        if_rvalid_q <= 1'b1;
        if_rdata_q  <= buf_data_q;
      end
`endif

      if (state_q == ISSUE)     lat_q <= LAT_LOAD;
      else if (state_q == WAIT) lat_q <= lat_q - LAT_W'(1);

      // Write acknowledges return zero rather than whatever the memory drives.
      if (done) begin
        if (owner_if_q) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= bus.mem_rdata;
        end else begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= we_q ? '0 : bus.mem_rdata;
        end
      end
    end
  end

`ifdef ARB_FETCH_BUF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (done && owner_if_q) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= mem_addr_q;
      buf_data_q  <= bus.mem_rdata;
    end else if (state_q == ISSUE && mem_we_q &&
                 ((mem_addr_q >> OFS_W) == (buf_addr_q >> OFS_W))) begin
      buf_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences and
// randomized traffic checked against a cycle-count/transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int SM      = 4;
`ifdef ARB_FETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0000_0013;
      1:       return 32'h0BAD_F00D;
      16:      return 32'h00A0_0093;
      64:      return 32'h1122_3344;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  // Memory model: byte-enabled writes, reads valid MEM_LAT cycles after mem_en.
  logic [31:0] mem_arr [256];
  logic [31:0] rd_pipe [MEM_LAT];
  bit          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem_arr[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_arr[bus.mem_addr[9:2]] : 32'h5A5A_5A5A;
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  logic [31:0] shadow [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One isolated transaction with full timing checks relative to the grant cycle.
  task automatic run_txn(input string name, input logic fetch, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic hit, input logic [31:0] exp_data);
    int t_g, t_r, wrong;
    logic       exp_we;
    logic [3:0] exp_be;
    exp_we = fetch ? 1'b0 : we;
    exp_be = fetch ? 4'hF : be;
    @(posedge clk); #1;
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
    end
    t_g = -1;
    for (int i = 0; i < 20 && t_g < 0; i++) begin
      @(negedge clk);
      if (fetch ? bus.if_gnt : bus.d_gnt) begin
        t_g = cyc;
        check({name, "_other_gnt"}, 64'(fetch ? bus.d_gnt : bus.if_gnt), 64'(0));
      end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check({name, "_gnt_seen"}, 64'(t_g >= 0), 64'(1));
    if (t_g < 0) return;
    if (!fetch && we) model_write(addr, wdata, be);
    @(negedge clk);
    if (hit) begin
      check({name, "_hit_no_mem_en"}, 64'(bus.mem_en), 64'(0));
    end else begin
      check({name, "_issue_ctrl"}, 64'({bus.mem_en, bus.mem_we, bus.mem_be}), 64'({1'b1, exp_we, exp_be}));
      check({name, "_issue_addr"}, 64'(bus.mem_addr), 64'(addr));
      if (!fetch && we) check({name, "_issue_wdata"}, 64'(bus.mem_wdata), 64'(wdata));
    end
    t_r = -1;
    wrong = 0;
    for (int i = 0; i < 20 && t_r < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1 && !hit) check({name, "_mem_en_pulse"}, 64'(bus.mem_en), 64'(0));
      if (fetch ? bus.if_rvalid : bus.d_rvalid) t_r = cyc;
      if (fetch ? bus.d_rvalid : bus.if_rvalid) wrong++;
    end
    check({name, "_latency"}, 64'(t_r - t_g), 64'(hit ? 1 : MEM_LAT + 2));
    check({name, "_rdata"}, 64'(fetch ? bus.if_rdata : bus.d_rdata), 64'(exp_data));
    check({name, "_other_rvalid"}, 64'(wrong), 64'(0));
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  // Random traffic against a reference model built on grant cycles and a shadow memory.
  task automatic run_random(input int ncyc);
    int  next_free, starve, pend_cyc;
    bit  pend_valid, pend_if, bv, ig_prev, dg_prev, exp_ig, exp_dg, exp_irv, exp_drv;
    logic [31:0] pend_data, ba, bd;
    next_free = 0; starve = 0; pend_cyc = 0; pend_valid = 0; pend_if = 0;
    bv = 0; ba = '0; bd = '0; ig_prev = 0; dg_prev = 0; pend_data = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (ig_prev) bus.if_req = 1'b0;
      if (dg_prev) bus.d_req  = 1'b0;
      if (c < ncyc - 30) begin
        if (!bus.if_req && $urandom_range(0, 2) == 0) begin
          bus.if_req  = 1'b1;
          bus.if_addr = 32'($urandom_range(0, 7)) << 2;
        end
        if (!bus.d_req && $urandom_range(0, 1) == 0) begin
          bus.d_req   = 1'b1;
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_addr  = 32'($urandom_range(0, 15)) << 2;
          bus.d_wdata = $urandom;
          bus.d_be    = 4'($urandom_range(1, 15));
        end
      end
      @(negedge clk);
      exp_irv = pend_valid && pend_cyc == cyc && pend_if;
      exp_drv = pend_valid && pend_cyc == cyc && !pend_if;
      check("rand_rvalid", 64'({bus.if_rvalid, bus.d_rvalid}), 64'({exp_irv, exp_drv}));
      if (exp_irv) check("rand_if_rdata", 64'(bus.if_rdata), 64'(pend_data));
      if (exp_drv) check("rand_d_rdata", 64'(bus.d_rdata), 64'(pend_data));
      if (pend_valid && pend_cyc == cyc) pend_valid = 0;

      exp_ig = 0; exp_dg = 0;
      if (cyc >= next_free) begin
        if (bus.if_req && (!bus.d_req || starve == SM)) exp_ig = 1;
        else if (bus.d_req)                           exp_dg = 1;
      end
      check("rand_gnt", 64'({bus.if_gnt, bus.d_gnt}), 64'({exp_ig, exp_dg}));

      if (exp_dg) begin
        if (bus.if_req) starve = (starve < SM) ? starve + 1 : SM;
        if (bus.d_we) begin
          model_write(bus.d_addr, bus.d_wdata, bus.d_be);
          pend_data = '0;
          if (bv && ba[31:2] == bus.d_addr[31:2]) bv = 0;
        end else begin
          pend_data = shadow[bus.d_addr[9:2]];
        end
        pend_if = 0; pend_valid = 1; pend_cyc = cyc + MEM_LAT + 2; next_free = pend_cyc;
      end
      if (exp_ig) begin
        starve = 0; pend_if = 1; pend_valid = 1;
        if (BUF_EN && bv && ba == bus.if_addr) begin
          pend_data = bd;
          pend_cyc  = cyc + 1;
        end else begin
          pend_data = shadow[bus.if_addr[9:2]];
          pend_cyc  = cyc + MEM_LAT + 2;
          if (BUF_EN) begin bv = 1; ba = bus.if_addr; bd = pend_data; end
        end
        next_free = pend_cyc;
      end
      ig_prev = bus.if_gnt;
      dg_prev = bus.d_gnt;
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check("rand_drain", 64'(pend_valid), 64'(0));
  endtask

  initial begin
    int g_t[2], r_t[2], gn, rvn, ng, both, rv_seen;
    logic [31:0] r_d[2];
    logic order[10];

    vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,         4'hF, 32'h00A0_0093};
    vecs[1] = '{1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h100, 32'h0,         4'hF, 32'h1122_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0,         4'hF, 32'h1122_BEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h104, 32'h0,         4'hF, 32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b1, 32'h100, 32'hA5A5_0000, 4'hC, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h100, 32'h0,         4'hF, 32'hA5A5_BEEF};
    vecs[8] = '{1'b1, 1'b0, 32'h40,  32'h0,         4'hF, 32'h00A0_0093};

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    repeat (3) @(posedge clk); #1;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    #1;
    check("reset_gnt", 64'({bus.if_gnt, bus.d_gnt}), 64'(0));
    check("reset_ctrl", 64'({bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.mem_be}), 64'(0));
    check("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 64'(0));
    check("reset_rdata", {bus.if_rdata, bus.d_rdata}, 64'(0));
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].fetch, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].be, 1'b0, vecs[i].exp);

    // Reset while a read sits in WAIT.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104; bus.d_be = 4'hF;
    @(negedge clk);
    check("abort_gnt", 64'(bus.d_gnt), 64'(1));
    @(posedge clk); #1 bus.d_req = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("abort_ctrl", 64'({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid,
                             bus.mem_en, bus.mem_we, bus.mem_be}), 64'(0));
    check("abort_mem_bus", {bus.mem_addr, bus.mem_wdata}, 64'(0));
    check("abort_rdata", {bus.if_rdata, bus.d_rdata}, 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.if_rvalid || bus.d_rvalid) rv_seen++;
    end
    check("abort_no_rvalid", 64'(rv_seen), 64'(0));
    run_txn("after_abort", 1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D);

    // Back-to-back data reads: second grant lands on the first rvalid cycle.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_be = 4'hF;
    gn = 0; rvn = 0;
    g_t[0] = -1; g_t[1] = -2; r_t[0] = -3; r_t[1] = -4; r_d[0] = '0; r_d[1] = '0;
    for (int i = 0; i < 40 && rvn < 2; i++) begin
      logic saw_gnt;
      @(negedge clk);
      saw_gnt = bus.d_gnt;
      if (bus.d_gnt && gn < 2) begin g_t[gn] = cyc; gn++; end
      if (bus.d_rvalid && rvn < 2) begin r_t[rvn] = cyc; r_d[rvn] = bus.d_rdata; rvn++; end
      @(posedge clk); #1;
      if (saw_gnt) begin
        if (gn == 1) bus.d_addr = 32'h4;
        else         bus.d_req  = 1'b0;
      end
    end
    bus.d_req = 1'b0;
    check("b2b_counts", 64'({gn[7:0], rvn[7:0]}), 64'({8'd2, 8'd2}));
    check("b2b_first_lat", 64'(r_t[0] - g_t[0]), 64'(MEM_LAT + 2));
    check("b2b_gnt_on_rvalid", 64'(g_t[1] - r_t[0]), 64'(0));
    check("b2b_rvalid_gap", 64'(r_t[1] - r_t[0]), 64'(MEM_LAT + 2));
    check("b2b_data0", 64'(r_d[0]), 64'(32'h0000_0013));
    check("b2b_data1", 64'(r_d[1]), 64'(32'h0BAD_F00D));

    // Both requesters held high: data wins SM times, then fetch.
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h204; bus.d_be = 4'hF;
    ng = 0; both = 0;
    for (int k = 0; k < 10; k++) order[k] = 1'bx;
    for (int i = 0; i < 300 && ng < 10; i++) begin
      @(negedge clk);
      if (bus.if_gnt && bus.d_gnt) both++;
      else if (bus.if_gnt) begin order[ng] = 1'b1; ng++; end
      else if (bus.d_gnt)  begin order[ng] = 1'b0; ng++; end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (MEM_LAT + 4) @(posedge clk);
    check("starve_grants", 64'(ng), 64'(10));
    check("starve_double_gnt", 64'(both), 64'(0));
    for (int k = 0; k < 10; k++)
      check($sformatf("starve_order%0d", k), 64'(order[k]), 64'((k % (SM + 1)) == SM));

`ifdef ARB_FETCH_BUF_EN
    run_txn("buf_miss", 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, init_word(32));
    run_txn("buf_hit",  1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, init_word(32));
    run_txn("buf_wr",   1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    run_txn("buf_inval", 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 32'h1234_5678);
`endif

    do_reset();
    run_random(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
